// File: rtl/memory_stage_if.sv
// Data-bus response channel between the memory stage and the data memory.
// The memory side drives the response pulse and read word.
`ifndef MEM_STAGE_CTRL_DEFS
`define MEM_STAGE_CTRL_DEFS
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LWL   7
`define I_LWR   8
`define I_MAX   9
`endif

interface memory_stage_if;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    input data_data_ok,
    input data_rdata
  );

  modport slave (
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: waits for the data response, aligns loads, registers the writeback payload.
// Optional MEM_LOAD_FWD_EN lets loads forward to decode in their completion cycle.
`ifndef MEM_STAGE_CTRL_DEFS
`define MEM_STAGE_CTRL_DEFS
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LWL   7
`define I_LWR   8
`define I_MAX   9
`endif

module memory_stage (
  input  logic               clk,
  input  logic               resetn,
  memory_stage_if.master     dbus,
  input  logic               valid_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        inst_i,
  input  logic [`I_MAX-1:0]  ctrl_i,
  input  logic [31:0]        result_i,
  input  logic [31:0]        eaddr_i,
  input  logic [31:0]        rdata2_i,
  input  logic [4:0]         waddr_i,
  input  logic               ready_i,
  output logic               done_o,
  output logic               valid_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        inst_o,
  output logic [`I_MAX-1:0]  ctrl_o,
  output logic [31:0]        result_o,
  output logic [4:0]         waddr_o,
  output logic [4:0]         fwd_addr,
  output logic [31:0]        fwd_data,
  output logic               fwd_ok
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  logic               valid_o_q, valid_o_d;
  logic [31:0]        pc_o_q, pc_o_d;
  logic [31:0]        inst_o_q, inst_o_d;
  logic [`I_MAX-1:0]  ctrl_o_q, ctrl_o_d;
  logic [31:0]        result_o_q, result_o_d;
  logic [4:0]         waddr_o_q, waddr_o_d;

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [5:0]  lwl_mask_sh;
  logic [31:0] aligned;
  logic [31:0] load_data;
  logic [31:0] sel_result;
  logic        mem_req;
  logic        unused_eaddr;

  assign unused_eaddr = ^eaddr_i[31:2];

  // Load alignment from the raw bus word.
  always_comb begin
    off         = eaddr_i[1:0];
    byte_sel    = dbus.data_rdata[{off, 3'b000} +: 8];
    half_sel    = off[1] ? dbus.data_rdata[31:16] : dbus.data_rdata[15:0];
    lwl_mask_sh = {1'b0, off, 3'b000} + 6'd8;
    aligned     = dbus.data_rdata;
    if (ctrl_i[`I_LB])
      aligned = {{24{byte_sel[7]}}, byte_sel};
    else if (ctrl_i[`I_LBU])
      aligned = {24'd0, byte_sel};
    else if (ctrl_i[`I_LH])
      aligned = {{16{half_sel[15]}}, half_sel};
    else if (ctrl_i[`I_LHU])
      aligned = {16'd0, half_sel};
    else if (ctrl_i[`I_LWL])
      aligned = (dbus.data_rdata << {~off, 3'b000}) |
                (rdata2_i & (32'hffff_ffff >> lwl_mask_sh));
    else if (ctrl_i[`I_LWR])
      aligned = (dbus.data_rdata >> {off, 3'b000}) |
                (rdata2_i & ~(32'hffff_ffff >> {off, 3'b000}));
  end

  always_comb begin
    mem_req    = valid_i && (ctrl_i[`I_MEM_R] || ctrl_i[`I_MEM_W]);
    // Once held, the bus word is stale; only the latched aligned value is trusted.
    load_data  = (state_q == HOLD) ? hold_q : aligned;
    sel_result = ctrl_i[`I_MEM_R] ? load_data : result_i;
    done_o     = !mem_req || (state_q == HOLD) || dbus.data_data_ok;

    fwd_addr = valid_i ? waddr_i : 5'd0;
    fwd_data = sel_result;
`ifdef MEM_LOAD_FWD_EN
    fwd_ok   = valid_i && done_o && ctrl_i[`I_WEX];
`else
    fwd_ok   = valid_i && done_o && ctrl_i[`I_WEX] && !ctrl_i[`I_MEM_R];
`endif
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (!dbus.data_data_ok) begin
            state_d = WAIT;
          end else if (!ready_i) begin
            state_d = HOLD;
            hold_d  = aligned;
          end
        end
      end
      WAIT: begin
        if (dbus.data_data_ok) begin
          if (ready_i) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            hold_d  = aligned;
          end
        end
      end
      HOLD: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o_d  = valid_o_q;
    pc_o_d     = pc_o_q;
    inst_o_d   = inst_o_q;
    ctrl_o_d   = ctrl_o_q;
    result_o_d = result_o_q;
    waddr_o_d  = waddr_o_q;
    if (ready_i) begin
      valid_o_d  = valid_i && done_o;
      pc_o_d     = pc_i;
      inst_o_d   = inst_i;
      ctrl_o_d   = ctrl_i;
      result_o_d = sel_result;
      waddr_o_d  = waddr_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      valid_o_q  <= 1'b0;
      pc_o_q     <= '0;
      inst_o_q   <= '0;
      ctrl_o_q   <= '0;
      result_o_q <= '0;
      waddr_o_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      valid_o_q  <= valid_o_d;
      pc_o_q     <= pc_o_d;
      inst_o_q   <= inst_o_d;
      ctrl_o_q   <= ctrl_o_d;
      result_o_q <= result_o_d;
      waddr_o_q  <= waddr_o_d;
    end
  end

  assign valid_o  = valid_o_q;
  assign pc_o     = pc_o_q;
  assign inst_o   = inst_o_q;
  assign ctrl_o   = ctrl_o_q;
  assign result_o = result_o_q;
  assign waddr_o  = waddr_o_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed loads/stores/ALU ops, stalls and reset mid-wait.
`ifndef MEM_STAGE_CTRL_DEFS
`define MEM_STAGE_CTRL_DEFS
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LWL   7
`define I_LWR   8
`define I_MAX   9
`endif

module tb_memory_stage;
  localparam int W = `I_MAX;
  localparam logic [W-1:0] C_ALU = W'(1 << `I_WEX);
  localparam logic [W-1:0] C_LW  = W'((1 << `I_MEM_R) | (1 << `I_WEX));
  localparam logic [W-1:0] C_LB  = W'((1 << `I_MEM_R) | (1 << `I_WEX) | (1 << `I_LB));
  localparam logic [W-1:0] C_LBU = W'((1 << `I_MEM_R) | (1 << `I_WEX) | (1 << `I_LBU));
  localparam logic [W-1:0] C_LH  = W'((1 << `I_MEM_R) | (1 << `I_WEX) | (1 << `I_LH));
  localparam logic [W-1:0] C_LHU = W'((1 << `I_MEM_R) | (1 << `I_WEX) | (1 << `I_LHU));
  localparam logic [W-1:0] C_LWL = W'((1 << `I_MEM_R) | (1 << `I_WEX) | (1 << `I_LWL));
  localparam logic [W-1:0] C_LWR = W'((1 << `I_MEM_R) | (1 << `I_WEX) | (1 << `I_LWR));
  localparam logic [W-1:0] C_SW  = W'(1 << `I_MEM_W);

  logic          clk = 1'b0;
  logic          resetn;
  logic          valid_i, ready_i;
  logic [31:0]   pc_i, inst_i, result_i, eaddr_i, rdata2_i;
  logic [W-1:0]  ctrl_i;
  logic [4:0]    waddr_i;
  logic          done_o, valid_o, fwd_ok;
  logic [31:0]   pc_o, inst_o, result_o, fwd_data;
  logic [W-1:0]  ctrl_o;
  logic [4:0]    waddr_o, fwd_addr;

  memory_stage_if dbus_if();

  memory_stage dut (
    .clk      (clk),
    .resetn   (resetn),
    .dbus     (dbus_if.master),
    .valid_i  (valid_i),
    .pc_i     (pc_i),
    .inst_i   (inst_i),
    .ctrl_i   (ctrl_i),
    .result_i (result_i),
    .eaddr_i  (eaddr_i),
    .rdata2_i (rdata2_i),
    .waddr_i  (waddr_i),
    .ready_i  (ready_i),
    .done_o   (done_o),
    .valid_o  (valid_o),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .ctrl_o   (ctrl_o),
    .result_o (result_o),
    .waddr_o  (waddr_o),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .fwd_ok   (fwd_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  waddr;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic        took;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a payload is retired on every edge where ready_i was high and valid_o then rises.
  always @(posedge clk) begin
    took = ready_i && resetn;
    #2;
    if (took && valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result_o, e.res);
        chk({e.name, "_pc"}, pc_o, e.pc);
        chk({e.name, "_waddr"}, {27'd0, waddr_o}, {27'd0, e.waddr});
        $display("[TB] retire %s pc=%08h result=%08h", e.name, pc_o, result_o);
      end
    end
  end

  function automatic logic load_fwd_expected(input logic [W-1:0] c);
`ifdef MEM_LOAD_FWD_EN
    return c[`I_WEX];
`else
    return c[`I_WEX] && !c[`I_MEM_R];
`endif
  endfunction

  // lat = cycles before data_ok; stall = cycles with ready_i low after data_ok.
  task automatic run_txn(input string name, input logic [W-1:0] c, input logic [31:0] ea,
                         input logic [31:0] res, input logic [31:0] rd2, input logic [31:0] rd,
                         input int lat, input int stall, input logic [4:0] wa,
                         input logic [31:0] exp);
    logic is_mem;
    int   total;
    exp_t e;
    is_mem = c[`I_MEM_R] || c[`I_MEM_W];
    total  = is_mem ? (lat + 1 + stall) : 1;
    e.name = name; e.pc = pc_ctr; e.res = exp; e.waddr = wa;
    @(negedge clk);
    valid_i = 1'b1; pc_i = pc_ctr; inst_i = pc_ctr ^ 32'ha5a5_0000; ctrl_i = c;
    result_i = res; eaddr_i = ea; rdata2_i = rd2; waddr_i = wa;
    pc_ctr = pc_ctr + 32'd4;
    for (int cy = 0; cy < total; cy++) begin
      if (cy > 0) @(negedge clk);
      if (!is_mem) begin
        dbus_if.data_data_ok = 1'b0; dbus_if.data_rdata = $urandom; ready_i = 1'b1;
        sb.push_back(e);
        #1;
        chk({name, "_done"}, {31'd0, done_o}, 32'd1);
        chk({name, "_fwd_ok"}, {31'd0, fwd_ok}, {31'd0, c[`I_WEX]});
        chk({name, "_fwd_data"}, fwd_data, exp);
        chk({name, "_fwd_addr"}, {27'd0, fwd_addr}, {27'd0, wa});
      end else if (cy < lat) begin
        dbus_if.data_data_ok = 1'b0; dbus_if.data_rdata = $urandom; ready_i = 1'b1;
        #1;
        chk({name, "_wait_done"}, {31'd0, done_o}, 32'd0);
        chk({name, "_wait_fwd_ok"}, {31'd0, fwd_ok}, 32'd0);
      end else if (cy == lat) begin
        dbus_if.data_data_ok = 1'b1; dbus_if.data_rdata = rd; ready_i = (stall == 0);
        if (stall == 0) sb.push_back(e);
        #1;
        chk({name, "_ok_done"}, {31'd0, done_o}, 32'd1);
        chk({name, "_ok_fwd_ok"}, {31'd0, fwd_ok}, {31'd0, load_fwd_expected(c)});
        chk({name, "_ok_fwd_data"}, fwd_data, exp);
      end else begin
        dbus_if.data_data_ok = 1'b0; dbus_if.data_rdata = $urandom; ready_i = (cy == total - 1);
        if (cy == total - 1) sb.push_back(e);
        #1;
        chk({name, "_hold_done"}, {31'd0, done_o}, 32'd1);
        chk({name, "_hold_fwd_data"}, fwd_data, exp);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_i = 1'b0; dbus_if.data_data_ok = 1'b0; ready_i = 1'b1; ctrl_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; valid_i = 1'b0; ready_i = 1'b1; pc_i = '0; inst_i = '0; ctrl_i = '0;
    result_i = '0; eaddr_i = '0; rdata2_i = '0; waddr_i = '0;
    dbus_if.data_data_ok = 1'b0; dbus_if.data_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset_result_o", result_o, 32'd0);
    chk("reset_pc_o", pc_o, 32'd0);
    chk("reset_ctrl_o", {23'd0, ctrl_o}, 32'd0);
    resetn = 1'b1;
    idle_cycle();

    run_txn("addu",    C_ALU, 32'h0,     32'd7,         32'h0,         32'h0,         0, 0, 5'd5, 32'd7);
    run_txn("lw",      C_LW,  32'h100,   32'h0,         32'h0,         32'h11223344,  2, 0, 5'd3, 32'h11223344);
    run_txn("lb",      C_LB,  32'h103,   32'h0,         32'h0,         32'h80ffffff,  0, 0, 5'd4, 32'hffffff80);
    run_txn("lbu",     C_LBU, 32'h103,   32'h0,         32'h0,         32'h80ffffff,  0, 0, 5'd4, 32'h00000080);
    run_txn("lh",      C_LH,  32'h102,   32'h0,         32'h0,         32'h80010000,  1, 0, 5'd6, 32'hffff8001);
    run_txn("lhu",     C_LHU, 32'h102,   32'h0,         32'h0,         32'h80010000,  0, 0, 5'd6, 32'h00008001);
    run_txn("lwl_o1",  C_LWL, 32'h101,   32'h0,         32'h11223344,  32'haabbccdd,  0, 0, 5'd7, 32'hccdd3344);
    run_txn("lwr_o2",  C_LWR, 32'h102,   32'h0,         32'h11223344,  32'haabbccdd,  1, 0, 5'd7, 32'h1122aabb);
    run_txn("lwl_o3",  C_LWL, 32'h103,   32'h0,         32'h11223344,  32'haabbccdd,  0, 0, 5'd7, 32'haabbccdd);
    run_txn("lwr_o0",  C_LWR, 32'h100,   32'h0,         32'h11223344,  32'haabbccdd,  0, 0, 5'd7, 32'haabbccdd);
    run_txn("sw",      C_SW,  32'h200,   32'hdeadbeef,  32'h0,         32'h0,         1, 0, 5'd0, 32'hdeadbeef);
    run_txn("lw_stall",C_LW,  32'h104,   32'h0,         32'h0,         32'h55667788,  1, 3, 5'd9, 32'h55667788);
    run_txn("lb_stall",C_LB,  32'h101,   32'h0,         32'h0,         32'h1234f600,  0, 2, 5'd10, 32'hfffffff6);
    run_txn("addu2",   C_ALU, 32'h0,     32'h0badf00d,  32'h0,         32'h0,         0, 0, 5'd11, 32'h0badf00d);

    // Reset while an LW waits for its response.
    @(negedge clk);
    valid_i = 1'b1; pc_i = 32'h0000_9000; ctrl_i = C_LW; eaddr_i = 32'h300; waddr_i = 5'd12;
    dbus_if.data_data_ok = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midwait_reset_valid_o", {31'd0, valid_o}, 32'd0);
    chk("midwait_reset_pc_o", pc_o, 32'd0);
    chk("midwait_reset_result_o", result_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1; valid_i = 1'b0; ctrl_i = '0;
    @(negedge clk);
    dbus_if.data_data_ok = 1'b1; dbus_if.data_rdata = 32'hbad0bad0;
    run_txn("lw_after_reset", C_LW, 32'h304, 32'h0, 32'h0, 32'hcafef00d, 1, 0, 5'd13, 32'hcafef00d);
    run_txn("lw_zero_wait",   C_LW, 32'h308, 32'h0, 32'h0, 32'h01020304, 0, 1, 5'd14, 32'h01020304);

    repeat (4) idle_cycle();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
